// File: rtl/universal_shift_reg_n.sv
// ---------------------------------------------------------------------------
// universal_shift_reg_n
//
// Purpose:
//   Parametrised N-bit universal shift register. It supports SISO, SIPO,
//   PISO and PIPO use, with left/right shifting and parallel load. A built-in
//   burst controller shifts exactly N bits after one start pulse and then
//   pulses done.
//
// Parameters:
//   N      register width in bits (N >= 2)
//   CNT_W  burst counter width, derived as $clog2(N)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset; clears all state
//   en            clock enable for manual mode operations and burst shifts
//   mode[1:0]     manual operation in IDLE:
//                   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   par_in[N-1:0] parallel load data
//   serial_in_r   bit entering q[N-1] on a right shift
//   serial_in_l   bit entering q[0] on a left shift
//   start         single-cycle burst request (accepted only in IDLE)
//   dir           burst direction, sampled with start: 0 right, 1 left
//   par_out       register contents q
//   serial_out_r  q[0], the bit leaving on a right shift
//   serial_out_l  q[N-1], the bit leaving on a left shift
//   busy          high while a burst is in progress (decode of the state reg)
//   done          one-cycle pulse after the final burst shift
//   shift_cnt     number of burst shifts completed in the current burst
//
// Handshake:
//   start is a request with no ready. It is accepted on any rising edge
//   where the controller is in IDLE, regardless of en or mode. While busy is
//   high, start is ignored. Completion is signalled by done, which is high
//   for exactly one cycle. busy therefore serves as the inverse of "ready".
// ---------------------------------------------------------------------------
module universal_shift_reg_n #(
  parameter  int N     = 8,
  localparam int CNT_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     par_in,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic             start,
  input  logic             dir,
  output logic [N-1:0]     par_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shift_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Count value at which the Nth (final) burst shift takes place.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  state_t           state_q, state_d;
  logic [N-1:0]     q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  // Shifted versions of the register. Both manual modes and the burst
  // engine use these.
  logic [N-1:0] shr_val;
  logic [N-1:0] shl_val;

  assign shr_val = {serial_in_r, q_q[N-1:1]};
  assign shl_val = {q_q[N-2:0], serial_in_l};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // start wins over any manual mode. q is left untouched on the
          // accepting edge, so the first shift lands on the next en edge.
          state_d = SHIFT;
          cnt_d   = '0;
          dir_d   = dir;
        end else if (en) begin
          case (mode)
            MODE_RIGHT: q_d = shr_val;
            MODE_LEFT:  q_d = shl_val;
            MODE_LOAD:  q_d = par_in;
            MODE_HOLD:  q_d = q_q;
            default:    q_d = q_q;
          endcase
        end
      end

      SHIFT: begin
        // mode, par_in and start are ignored for the whole burst. When en is
        // low the burst simply stalls with q and the count frozen.
        if (en) begin
          q_d = dir_q ? shl_val : shr_val;
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs: direct register taps
  // -------------------------------------------------------------------------
  assign par_out      = q_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[N-1];
  assign busy         = (state_q == SHIFT);
  assign done         = done_q;
  assign shift_cnt    = cnt_q;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// ---------------------------------------------------------------------------
// Testbench for universal_shift_reg_n. An 8-bit instance covers the manual
// modes, bursts, stalls and resets. A 4-bit instance covers SISO behaviour.
// ---------------------------------------------------------------------------
module tb_universal_shift_reg_n;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // 8-bit DUT
  // -------------------------------------------------------------------------
  logic       en, sr, sl, start, dir;
  logic [1:0] mode;
  logic [7:0] par_in;
  logic [7:0] po;
  logic       sor, sol, busy, done;
  logic [2:0] cnt;

  universal_shift_reg_n #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .par_in(par_in),
    .serial_in_r(sr), .serial_in_l(sl), .start(start), .dir(dir),
    .par_out(po), .serial_out_r(sor), .serial_out_l(sol),
    .busy(busy), .done(done), .shift_cnt(cnt)
  );

  // -------------------------------------------------------------------------
  // 4-bit DUT
  // -------------------------------------------------------------------------
  logic       en4, sr4, sl4, start4, dir4;
  logic [1:0] mode4;
  logic [3:0] par4;
  logic [3:0] po4;
  logic       sor4, sol4, busy4, done4;
  logic [1:0] cnt4;

  universal_shift_reg_n #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .mode(mode4), .par_in(par4),
    .serial_in_r(sr4), .serial_in_l(sl4), .start(start4), .dir(dir4),
    .par_out(po4), .serial_out_r(sor4), .serial_out_l(sol4),
    .busy(busy4), .done(done4), .shift_cnt(cnt4)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance past the rising edge, then sample.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] v);
    en = 1'b1; mode = 2'b11; par_in = v;
    step();
    mode = 2'b00;
  endtask

  // -------------------------------------------------------------------------
  // Vector table for manual operations on the 8-bit instance
  // -------------------------------------------------------------------------
  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] par;
    logic       sr;
    logic       sl;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[9];

  // Watchdog. Every wait in the bench is a fixed number of cycles; this
  // guards against the clock or the scheduler misbehaving.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bits4;
    logic [7:0] expq;
    int         shifts;
    int         done_seen;
    logic       exp_done;

    vecs[0] = '{1'b1, 2'b11, 8'hA5, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{1'b1, 2'b01, 8'h00, 1'b1, 1'b0, 8'hD2};
    vecs[2] = '{1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 8'hA4};
    vecs[3] = '{1'b1, 2'b00, 8'hFF, 1'b1, 1'b1, 8'hA4};
    vecs[4] = '{1'b1, 2'b00, 8'h00, 1'b0, 1'b1, 8'hA4};
    vecs[5] = '{1'b1, 2'b00, 8'h5A, 1'b1, 1'b0, 8'hA4};
    vecs[6] = '{1'b0, 2'b11, 8'hFF, 1'b1, 1'b1, 8'hA4};
    vecs[7] = '{1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'h52};
    vecs[8] = '{1'b1, 2'b10, 8'h00, 1'b1, 1'b1, 8'hA5};

    rst = 1'b1;
    en = 1'b0; mode = 2'b00; par_in = '0; sr = 1'b0; sl = 1'b0;
    start = 1'b0; dir = 1'b0;
    en4 = 1'b0; mode4 = 2'b00; par4 = '0; sr4 = 1'b0; sl4 = 1'b0;
    start4 = 1'b0; dir4 = 1'b0;

    #2;
    chk("reset_q", po, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cnt", cnt, 0);
    #10 rst = 1'b0;

    // ---- SISO on the 4-bit instance ----------------------------------------
    bits4 = 8'b1010_0001;  // bit k is the k-th serial input: 1,0,0,0,0,1,0,1
    en4 = 1'b1; mode4 = 2'b01;
    for (int k = 0; k < 12; k++) begin
      sr4 = (k < 8) ? bits4[k] : 1'b0;
      step();
      if (k == 3) chk("siso_q_after4", po4, 4'b0001);
      if (k >= 3 && k < 11) chk($sformatf("siso_out%0d", k - 3), sor4, bits4[k - 3]);
    end
    en4 = 1'b0; mode4 = 2'b00;

    // ---- Table-driven manual operations ------------------------------------
    for (int i = 0; i < 9; i++) begin
      en = vecs[i].en; mode = vecs[i].mode; par_in = vecs[i].par;
      sr = vecs[i].sr; sl = vecs[i].sl;
      step();
      chk($sformatf("vec%0d_q", i), po, vecs[i].exp_q);
      chk($sformatf("vec%0d_sor", i), sor, vecs[i].exp_q[0]);
      chk($sformatf("vec%0d_sol", i), sol, vecs[i].exp_q[7]);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end
    mode = 2'b00;

    // ---- Asynchronous reset mid-cycle --------------------------------------
    load8(8'hA5);
    chk("prerst_q", po, 8'hA5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q", po, 8'h00);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", cnt, 0);
    #1 rst = 1'b0;

    // ---- Right burst from 3C -----------------------------------------------
    load8(8'h3C);
    sr = 1'b0; dir = 1'b0; start = 1'b1; mode = 2'b11; par_in = 8'hFF;
    step();
    start = 1'b0;
    chk("rb_start_busy", busy, 1);
    chk("rb_start_q", po, 8'h3C);
    chk("rb_start_cnt", cnt, 0);
    done_seen = 0;
    expq = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rb_sor%0d", i), sor, expq[i]);
      step();
      done_seen += int'(done);
      chk($sformatf("rb_cnt%0d", i), cnt, (i + 1) % 8);
      chk($sformatf("rb_busy%0d", i), busy, (i < 7));
    end
    chk("rb_final_q", po, 8'h00);
    chk("rb_done_count", done_seen, 1);
    chk("rb_done_last", done, 1);
    mode = 2'b00;
    step();
    chk("rb_done_drop", done, 0);

    // ---- Left burst with stall, stray start and mode=11 --------------------
    load8(8'h81);
    sl = 1'b1; dir = 1'b1; start = 1'b1; mode = 2'b11; par_in = 8'h55;
    step();
    start = 1'b0;
    chk("st_start_q", po, 8'h81);
    expq = 8'h81;
    shifts = 0;
    done_seen = 0;
    for (int c = 0; c < 11; c++) begin
      en = !(c >= 3 && c <= 5);
      start = (c == 4);
      dir = 1'b0;
      step();
      if (en) begin
        expq = {expq[6:0], 1'b1};
        shifts++;
      end
      exp_done = (c == 10);
      done_seen += int'(done);
      chk($sformatf("st_q%0d", c), po, expq);
      chk($sformatf("st_cnt%0d", c), cnt, shifts % 8);
      chk($sformatf("st_busy%0d", c), busy, (shifts < 8));
      chk($sformatf("st_done%0d", c), done, exp_done);
    end
    start = 1'b0; en = 1'b1; mode = 2'b00;
    chk("st_done_count", done_seen, 1);
    chk("st_final_q", po, 8'hFF);
    step();
    chk("st_after_q", po, 8'hFF);
    chk("st_after_busy", busy, 0);

    // ---- Reset mid-burst ---------------------------------------------------
    load8(8'hC3);
    sr = 1'b1; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mr_cnt5", cnt, 5);
    chk("mr_busy", busy, 1);
    chk("mr_q", po, 8'hFE);
    #2 rst = 1'b1;
    #1;
    chk("mr_rst_q", po, 8'h00);
    chk("mr_rst_busy", busy, 0);
    chk("mr_rst_cnt", cnt, 0);
    #1 rst = 1'b0;
    step();
    chk("mr_idle_busy", busy, 0);
    chk("mr_idle_q", po, 8'h00);

    // ---- Back-to-back bursts -----------------------------------------------
    load8(8'hF0);
    sr = 1'b1; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("bb1_done", done, 1);
    chk("bb1_q", po, 8'hFF);
    chk("bb1_busy", busy, 0);
    start = 1'b1; dir = 1'b1; sl = 1'b0; mode = 2'b11; par_in = 8'hAA;
    step();
    start = 1'b0;
    chk("bb2_busy", busy, 1);
    chk("bb2_cnt", cnt, 0);
    chk("bb2_q", po, 8'hFF);
    chk("bb2_done", done, 0);
    for (int i = 0; i < 7; i++) step();
    chk("bb2_busy7", busy, 1);
    chk("bb2_q7", po, 8'h80);
    step();
    chk("bb2_final_q", po, 8'h00);
    chk("bb2_final_done", done, 1);
    chk("bb2_final_busy", busy, 0);
    mode = 2'b00;
    step();
    chk("bb2_done_drop", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
